// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared constants, state type, pattern table and length mapping for the pattern sequencer
package pattern_seq_pkg;
  localparam int NSTEPS = 6;
  localparam int SW = 3;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [SW-1:0] PAT [0:NSTEPS-1] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b010};
  function automatic logic [SW-1:0] len_eff(input logic [SW-1:0] l);
    return (l == '0 || int'(l) > NSTEPS) ? SW'(NSTEPS) : l;
  endfunction
endpackage

// File: rtl/pattern_rom.sv
// pattern_rom: combinational step index to pattern word lookup
module pattern_rom
  import pattern_seq_pkg::*;
(
  input  logic [SW-1:0] step,
  output logic [SW-1:0] result
);
  assign result = (int'(step) < NSTEPS) ? PAT[step] : '0;
endmodule

// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl: start/pause/stop/loop sequencer driving the 6-step pattern with registered outputs
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          stop,
  input  logic          hold,
  input  logic          mode,
  input  logic [SW-1:0] len,
  output logic [SW-1:0] step,
  output logic [SW-1:0] result,
  output logic          busy,
  output logic          done,
  output logic          wrap
);
  state_t state, nxt_state;
  logic [SW-1:0] last, nxt_step, pat;
  logic nxt_done, nxt_wrap;
  pattern_rom u_rom (.step(nxt_step), .result(pat));
  always_comb begin
    nxt_state = state;
    nxt_step = step;
    nxt_done = 1'b0;
    nxt_wrap = 1'b0;
    if (stop) begin
      nxt_state = IDLE;
      nxt_step = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_step = '0;
          nxt_state = start ? RUN : IDLE;
        end
        RUN: begin
          if (hold) nxt_state = PAUSE;
          else if (step != last) nxt_step = step + SW'(1);
          else if (mode) begin
            nxt_step = '0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_state = DONE;
            nxt_done = 1'b1;
          end
        end
        PAUSE: nxt_state = hold ? PAUSE : RUN;
        default: begin
          nxt_state = IDLE;
          nxt_step = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      step <= '0;
      result <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      wrap <= 1'b0;
      last <= SW'(NSTEPS - 1);
    end else begin
      if (state == IDLE && start && !stop) last <= len_eff(len) - SW'(1);
      state <= nxt_state;
      step <= nxt_step;
      result <= pat;
      busy <= nxt_state == RUN || nxt_state == PAUSE;
      done <= nxt_done;
      wrap <= nxt_wrap;
    end
  end
endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb_pattern_seq_ctrl: scoreboard bench comparing the sequencer against a behavioural run model
module tb_pattern_seq_ctrl;
  logic clk = 1'b0, clr = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0, mode = 1'b0;
  logic [2:0] len = 3'd0;
  logic [2:0] step, result;
  logic busy, done, wrap;
  typedef struct packed {
    logic [2:0] step;
    logic [2:0] result;
    logic busy, done, wrap;
  } obs_t;
  obs_t q[$];
  int total = 0, bad = 0, cyc_n = 0;
  int pat [6] = '{0, 1, 3, 5, 7, 2};
  bit m_act = 0, m_pause = 0, m_fin = 0;
  int m_idx = 0, m_n = 6;

  pattern_seq_ctrl dut (.clk(clk), .clr(clr), .start(start), .stop(stop), .hold(hold), .mode(mode),
                        .len(len), .step(step), .result(result), .busy(busy), .done(done), .wrap(wrap));

  always #5 clk = ~clk;

  task cyc(input bit c, input bit s, input bit p, input bit h, input bit m, input int l);
    bit d, w;
    obs_t e;
    @(negedge clk);
    clr = c; start = s; stop = p; hold = h; mode = m; len = 3'(l);
    d = 0; w = 0;
    if (c) begin
      m_act = 0; m_pause = 0; m_fin = 0; m_idx = 0; m_n = 6;
    end else if (p) begin
      m_act = 0; m_pause = 0; m_fin = 0; m_idx = 0;
    end else if (m_fin) begin
      m_fin = 0; m_idx = 0;
    end else if (!m_act) begin
      m_idx = 0;
      if (s) begin
        m_act = 1;
        m_n = (l % 8 == 0 || l % 8 == 7) ? 6 : l % 8;
      end
    end else if (m_pause) begin
      if (!h) m_pause = 0;
    end else if (h) begin
      m_pause = 1;
    end else if (m_idx == m_n - 1) begin
      if (m) begin
        m_idx = 0; w = 1;
      end else begin
        m_act = 0; m_fin = 1; d = 1;
      end
    end else begin
      m_idx++;
    end
    e.step = 3'(m_idx);
    e.result = 3'(pat[m_idx]);
    e.busy = m_act;
    e.done = d;
    e.wrap = w;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      obs_t e, a;
      e = q.pop_front();
      a = '{step: step, result: result, busy: busy, done: done, wrap: wrap};
      total++;
      cyc_n++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cycle %0d: got step=%0d result=%b busy=%b done=%b wrap=%b, want step=%0d result=%b busy=%b done=%b wrap=%b",
                 cyc_n, a.step, a.result, a.busy, a.done, a.wrap, e.step, e.result, e.busy, e.done, e.wrap);
      end
    end
  end

  task idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 6);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 3);
    // one-shot full length
    cyc(0, 1, 0, 0, 0, 6);
    idle(8);
    // loop of 3, then drop mode to finish the pass
    cyc(0, 1, 0, 0, 1, 3);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 3);
    // hold at step 2 for three edges
    cyc(0, 1, 0, 0, 0, 6);
    cyc(0, 0, 0, 0, 0, 6);
    cyc(0, 0, 0, 0, 0, 6);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 6);
    idle(6);
    // stop at step 4
    cyc(0, 1, 0, 0, 0, 6);
    idle(4);
    cyc(0, 0, 1, 0, 0, 6);
    idle(2);
    // length boundaries and mid-run length change
    cyc(0, 1, 0, 0, 0, 0);  idle(8);
    cyc(0, 1, 0, 0, 0, 7);  idle(8);
    cyc(0, 1, 0, 0, 0, 1);  idle(3);
    cyc(0, 1, 0, 0, 0, 3);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 5);
    // clr mid-run, start+stop in idle, starts during run and done
    cyc(0, 1, 0, 0, 0, 6);
    idle(3);
    cyc(1, 0, 0, 0, 0, 6);
    cyc(0, 1, 1, 0, 0, 6);
    idle(1);
    cyc(0, 1, 0, 0, 0, 2);
    cyc(0, 1, 0, 0, 0, 5);
    cyc(0, 1, 0, 0, 0, 5);
    cyc(0, 1, 0, 0, 0, 5);
    idle(8);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0,
          $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    idle(2);
    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_seq_ctrl.md
Name: pattern_seq_ctrl

Overview:
Sequencing controller for the 3-bit step-counter/decoder pattern datapath. It starts, pauses, stops and loops the 6-step output pattern under control inputs, with a run length that is programmable per start. It supports one-shot and continuous modes, and reports busy, done and wrap status to the surrounding lab top level. All outputs are registered.

Parameters:
NSTEPS, 6, number of entries in the pattern table; also the maximum run length.
SW, 3, width of the step index and of the pattern word.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
clr  input  1  reset, synchronous, active-high.
start  input  1  request a run; sampled only in IDLE.
stop  input  1  abort the current run; any non-IDLE state goes to IDLE.
hold  input  1  freeze the step while asserted.
mode  input  1  0 = one-shot, 1 = loop; sampled at the last step of each pass.
len  input  SW  run length in steps; latched on an accepted start.
step  output  SW  current step index.
result  output  SW  pattern word for the current step.
busy  output  1  high in RUN and PAUSE.
done  output  1  one-cycle pulse when a one-shot run completes.
wrap  output  1  one-cycle pulse when a loop pass restarts at step 0.

Behaviour:
- Interface: one clock (clk). Reset clr is synchronous and active-high; there is no asynchronous reset path.
- Reset values on a clr edge: state IDLE, step=0, result=000, busy=0, done=0, wrap=0, latched length=6. clr overrides all other inputs.
- Pattern table, step to result:
  - 0 → 000
  - 1 → 001
  - 2 → 011
  - 3 → 101
  - 4 → 111
  - 5 → 010
- result always equals PAT(step), updated on the same edge as step.
- Effective length len_eff: len when 1 ≤ len ≤ 6; 6 when len is 0 or 7. The last step index is len_eff−1.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority per edge: clr, then stop, then the state-specific rules below.
- IDLE:
  - start=1 and stop=0 → RUN. Latch len_eff; step=0, result=000.
  - Otherwise stay in IDLE with step=0, result=000.
- RUN, hold=1: go to PAUSE; step unchanged.
- RUN, hold=0, step < last: step advances by 1.
- RUN, hold=0, step = last:
  - mode=1 → stay in RUN, step=0, wrap=1 for that one cycle.
  - mode=0 → DONE; step and result hold their last values; done=1 and busy=0 for that cycle.
- PAUSE:
  - hold=0 → RUN; step unchanged. Resuming costs one cycle.
  - hold=1 → stay in PAUSE.
- DONE: unconditionally go to IDLE next edge; step=0, result=000. A start seen in DONE is ignored.
- stop in RUN, PAUSE or DONE: next state IDLE, step=0, result=000, no done or wrap pulse.
- start while not in IDLE is ignored. start and stop together in IDLE: stop wins, stay in IDLE.
- A len change mid-run has no effect until the next accepted start.
- A mode change takes effect only when evaluated at the last step, so clearing mode ends a loop gracefully.
- Latency:
  - start sampled → busy=1 and step=0 on the next edge.
  - One-shot run: exactly len_eff RUN cycles, then one DONE cycle, when hold is never asserted.
- Width rules:
  - step never exceeds len_eff−1.
  - The step increment is computed modulo len_eff, never modulo 2^SW.

Decomposition:
- Package pattern_seq_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - NSTEPS and SW constants;
  - pattern table constant PAT[0:5];
  - len_eff mapping function.
- One sub-module, pattern_rom: a combinational step → result lookup. The controller registers its output.

Test Plan:
- clr, then start pulse with mode=0, len=6 → result 000,001,011,101,111,010 on cycles 1–6 with busy=1; cycle 7 done=1, busy=0; cycle 8 IDLE with result=000.
- mode=1, len=3 → 000,001,011,000,…; wrap=1 exactly in each cycle where step returns to 0. Clear mode during a pass → that pass ends at step 2, then a done pulse.
- hold sampled high at step 2 for 3 edges → step=2 visible for 5 consecutive cycles (RUN, 3×PAUSE, RUN), then step=3. No skipped or duplicated pattern values.
- stop asserted at step 4 → next cycle IDLE, step=0, result=000, busy=0, and no done pulse.
- Length boundaries:
  - len=0 and len=7 → 6-step runs.
  - len=1 → a single RUN cycle with result=000, then done.
  - len changed mid-run → no effect.
- clr at step 3 → next cycle all outputs at reset values. start and stop together in IDLE → stays in IDLE. start pulses during RUN or DONE → ignored.
